// File: rtl/set_reset_bank.sv
// Bank of independent sticky flags with per-channel level/edge set, shared
// auto-clear timeout, masked summary output and clear-on-read host snapshot.
module set_reset_bank #(
  parameter int unsigned           CHANNELS      = 8,
  parameter logic [CHANNELS-1:0]   INIT          = '0,
  parameter logic [CHANNELS-1:0]   SET_EDGE      = '0,
  parameter int unsigned           TIMEOUT_WIDTH = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [CHANNELS-1:0]      set,
  input  logic [CHANNELS-1:0]      clr,
  input  logic [TIMEOUT_WIDTH-1:0] timeout,
  input  logic [CHANNELS-1:0]      irq_mask,
  input  logic                     read_strobe,
  output logic [CHANNELS-1:0]      q,
  output logic                     any,
  output logic [CHANNELS-1:0]      read_data,
  output logic                     read_valid
);

  logic [CHANNELS-1:0]      r_q;
  logic [CHANNELS-1:0]      r_set_d;
  logic [CHANNELS-1:0]      r_read_data;
  logic                     r_read_valid;
  logic [TIMEOUT_WIDTH-1:0] r_cnt [CHANNELS];
  logic [CHANNELS-1:0]      w_ev;

  // Edge channels fire only on a 0->1 transition; level channels fire every cycle set is high.
  assign w_ev = (set & ~SET_EDGE) | (set & ~r_set_d & SET_EDGE);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_q          <= INIT;
      r_set_d      <= '0;
      r_read_data  <= '0;
      r_read_valid <= 1'b0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_set_d      <= set;
      r_read_valid <= read_strobe;
      if (read_strobe) begin
        r_read_data <= r_q;
      end
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        if (clr[i]) begin
          r_q[i]   <= 1'b0;
          r_cnt[i] <= '0;
        end else if (w_ev[i]) begin
          r_q[i]   <= 1'b1;
          r_cnt[i] <= timeout;
        end else if (read_strobe && r_q[i]) begin
          r_q[i]   <= 1'b0;
          r_cnt[i] <= '0;
        end else if (r_q[i] && (r_cnt[i] != '0)) begin
          // A count of zero means sticky, so only a running count can expire.
          if (r_cnt[i] == TIMEOUT_WIDTH'(1)) begin
            r_q[i]   <= 1'b0;
            r_cnt[i] <= '0;
          end else begin
            r_cnt[i] <= r_cnt[i] - TIMEOUT_WIDTH'(1);
          end
        end
      end
    end
  end

  assign q          = r_q;
  assign any        = |(r_q & irq_mask);
  assign read_data  = r_read_data;
  assign read_valid = r_read_valid;

endmodule

// File: doc/set_reset_bank.md
Name: set_reset_bank

Overview:
- Multi-channel generalisation of the single set/reset flag: CHANNELS independent sticky flags.
- Each flag has per-channel level/edge set mode, optional auto-clear timeout, host snapshot read with clear-on-read, and a masked "any flag" summary.
- Sits between pulse-sequencer trigger/status lines and the host register interface.
- Used for latched status, trigger arming and interrupt sources.

Parameters:
- CHANNELS, 8, number of flag channels (1..32).
- INIT, {CHANNELS{1'b0}}, per-channel value of q after reset.
- SET_EDGE, {CHANNELS{1'b0}}, per-channel mode: 1 = set on rising edge of set[i]; 0 = set while set[i] is high (level).
- TIMEOUT_WIDTH, 16, width of the auto-clear timeout counter.

Ports:
- clock  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high.
- set  input  CHANNELS  per-channel set request.
- clr  input  CHANNELS  per-channel clear request.
- timeout  input  TIMEOUT_WIDTH  auto-clear length in cycles, shared by all channels; 0 = sticky.
- irq_mask  input  CHANNELS  enable mask for the any output.
- read_strobe  input  1  host read: snapshot q and clear the flags that were set.
- q  output  CHANNELS  registered flag state.
- any  output  1  |(q & irq_mask), combinational from registered q.
- read_data  output  CHANNELS  registered snapshot of q.
- read_valid  output  1  one-cycle pulse, read_data valid.

Behaviour:
- Reset: q = INIT, all counters = 0, set-history register = 0, read_data = 0, read_valid = 0.
- Reset overrides every other input.
- Set event, per channel:
  - SET_EDGE[i]=0: ev[i] = set[i].
  - SET_EDGE[i]=1: ev[i] = set[i] & ~set_d[i], where set_d is set delayed one cycle and cleared by reset.
  - A set held high through reset therefore produces an edge event in the first cycle after reset deassertion.
- Per-channel priority each cycle, highest first: reset > clr[i] > ev[i] > read-clear > timeout expiry.
  - clr[i]: q[i]=0, cnt[i]=0.
  - ev[i]: q[i]=1, cnt[i]=timeout, sampled in that cycle. A retrigger while q[i]=1 reloads cnt[i].
  - Read-clear: when read_strobe=1, channels with q[i]=1 and no ev[i] in the same cycle go to q[i]=0, cnt[i]=0. A set coincident with a read wins, so q stays 1 and the event is not lost.
  - Timeout: when q[i]=1 and cnt[i]!=0, cnt[i] decrements each cycle. The cycle cnt[i]==1 clears q[i] and sets cnt[i]=0. Result: q[i] is high for exactly `timeout` cycles after the last set event.
- timeout=0 at the set event: cnt stays 0 and the flag is sticky until clr, read-clear or reset.
- Changing the timeout input does not affect counters already running.
- Level-mode channel with set held high and timeout!=0: the event repeats every cycle, cnt reloads, and q stays high until set drops plus `timeout` cycles.
- Read:
  - read_data <= q (pre-clear value) and read_valid <= 1 on the clock edge where read_strobe=1.
  - read_valid is 0 otherwise.
  - Back-to-back strobes each produce a snapshot.
- Latency: set/clr input to q is 1 cycle; q to any is 0 cycles; read_strobe to read_data/read_valid is 1 cycle.
- Counter width: cnt is TIMEOUT_WIDTH bits. Maximum hold is 2^TIMEOUT_WIDTH-1 cycles, with no wrap-around because the decrement stops at 0.

Test Plan:
- Reset values: INIT=8'hA5, assert reset for 2 cycles with set=8'hFF → q=8'hA5, read_valid=0. For an edge channel, the first cycle after reset sets q[i]=1.
- Priority: same cycle set[2]=1, clr[2]=1 → q[2]=0. Next cycle set[2]=1 alone → q[2]=1 one cycle later.
- Edge vs level: SET_EDGE=8'h01, hold set[0] and set[1] high 5 cycles, then pulse clr=8'h03 once while both sets remain high → q[0] stays 0, q[1] returns to 1 the cycle after clr.
- Timeout: timeout=5, single-cycle set[3] at cycle T → q[3]=1 for cycles T+1..T+5, 0 at T+6.
  - Retrigger at T+3 → q[3] stays high through T+8.
  - timeout=0 → q[3] stays 1 indefinitely.
- Clear-on-read: q=8'h0C, read_strobe with set[2]=1 same cycle → read_data=8'h0C, read_valid pulses 1 cycle, q becomes 8'h04.
- any: q=8'h10, irq_mask=8'h0F → any=0; irq_mask=8'h10 → any=1 in the same cycle. Read-clear of the flag → any=0 one cycle after the strobe.
